// File: rtl/binary16_pkg.sv
// Shared binary16 field constants, operand classes and the divider FSM states.
package binary16_pkg;

  localparam int          EXP_BIAS = 15;
  localparam logic [4:0]  EXP_MAX  = 5'h1F;
  localparam int          MAN_W    = 10;

  localparam logic [15:0] QNAN     = 16'h7E00;
  localparam logic [15:0] POS_INF  = 16'h7C00;

  typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_class_t;

  typedef enum logic [1:0] {ST_IDLE, ST_DIV, ST_NORM} div_state_t;

  // Subnormals (exp==0) are folded into FP_ZERO.
  function automatic fp_class_t classify(input logic [15:0] x);
    fp_class_t c;
    if (x[14:10] == 5'h00) begin
      c = FP_ZERO;
    end else if (x[14:10] == EXP_MAX) begin
      c = (x[9:0] != '0) ? FP_NAN : FP_INF;
    end else begin
      c = FP_NORM;
    end
    return c;
  endfunction

endpackage

// File: rtl/binary16_round.sv
// Normalise the 13-bit quotient, optionally round to nearest even, and clamp
// the exponent to the binary16 range (overflow -> inf, underflow -> zero).
module binary16_round
  import binary16_pkg::*;
#(
  parameter int ROUND_NEAREST = 0
) (
  input  logic              sign_i,
  input  logic signed [6:0] e_i,
  input  logic [12:0]       q_i,
  input  logic [11:0]       rem_i,
  output logic [15:0]       word_o
);

  logic [MAN_W-1:0]  man;
  logic              g;
  logic              s;
  logic signed [7:0] e_n;
  logic signed [7:0] e_r;
  logic              inc;
  logic [MAN_W:0]    man_sum;
  logic [MAN_W-1:0]  man_f;

  // q[12] is the integer bit; when it is clear the quotient is one place low.
  always_comb begin
    man     = '0;
    g       = 1'b0;
    s       = 1'b0;
    e_n     = {e_i[6], e_i};
    inc     = 1'b0;
    man_sum = '0;
    man_f   = '0;
    e_r     = '0;
    word_o  = '0;
    if (q_i[12]) begin
      man = q_i[11:2];
      g   = q_i[1];
      s   = q_i[0] | (|rem_i);
    end else begin
      man = q_i[10:1];
      g   = q_i[0];
      s   = |rem_i;
      e_n = {e_i[6], e_i} - 8'sd1;
    end
    inc     = (ROUND_NEAREST != 0) && g && (s || man[0]);
    man_sum = {1'b0, man} + {{MAN_W{1'b0}}, inc};
    if (man_sum[MAN_W]) begin
      man_f = '0;
      e_r   = e_n + 8'sd1;
    end else begin
      man_f = man_sum[MAN_W-1:0];
      e_r   = e_n;
    end
    if (e_r >= 8'sd31) begin
      word_o = {sign_i, EXP_MAX, {MAN_W{1'b0}}};
    end else if (e_r <= 8'sd0) begin
      word_o = {sign_i, 15'h0000};
    end else begin
      word_o = {sign_i, e_r[4:0], man_f};
    end
  end

endmodule

// File: rtl/binary16_div.sv
// Iterative binary16 divider: one restoring quotient bit per cycle, fixed
// 14-cycle latency. Handshake: an operand pair is taken on a rising clk_in
// edge where ready_out && data_valid_in; data_valid_in while busy is dropped;
// data_valid_out is a single-cycle pulse and result holds until the next one.
module binary16_div
  import binary16_pkg::*;
#(
  parameter int ROUND_NEAREST = 0
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        data_valid_in,
  output logic        ready_out,
  output logic [15:0] result,
  output logic        data_valid_out
);

  div_state_t        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              sign_q, sign_d;
  logic signed [6:0] e_q, e_d;
  logic [10:0]       div_q, div_d;
  logic [11:0]       rem_q, rem_d;
  logic [12:0]       quo_q, quo_d;
  fp_class_t         cls_a_q, cls_a_d;
  fp_class_t         cls_b_q, cls_b_d;
  logic [15:0]       result_q, result_d;
  logic              dvo_q, dvo_d;
  logic [15:0]       rounded_w;

  binary16_round #(.ROUND_NEAREST(ROUND_NEAREST)) u_round (
    .sign_i (sign_q),
    .e_i    (e_q),
    .q_i    (quo_q),
    .rem_i  (rem_q),
    .word_o (rounded_w)
  );

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      e_q      <= '0;
      div_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cls_a_q  <= FP_ZERO;
      cls_b_q  <= FP_ZERO;
      result_q <= '0;
      dvo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      e_q      <= e_d;
      div_q    <= div_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cls_a_q  <= cls_a_d;
      cls_b_q  <= cls_b_d;
      result_q <= result_d;
      dvo_q    <= dvo_d;
    end
  end

  // Next-state logic: accept in IDLE, 13 divide steps, then pick special or rounded word.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    e_d      = e_q;
    div_d    = div_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cls_a_d  = cls_a_q;
    cls_b_d  = cls_b_q;
    result_d = result_q;
    dvo_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (data_valid_in) begin
          sign_d  = a[15] ^ b[15];
          e_d     = $signed({2'b00, a[14:10]}) - $signed({2'b00, b[14:10]})
                    + 7'(EXP_BIAS);
          div_d   = {1'b1, b[9:0]};
          rem_d   = {2'b01, a[9:0]};
          quo_d   = '0;
          cls_a_d = classify(a);
          cls_b_d = classify(b);
          cnt_d   = 4'd12;
          state_d = ST_DIV;
        end
      end
      ST_DIV: begin
        // Partial remainder stays below 2*divisor, so 12 bits never overflow.
        if (rem_q >= {1'b0, div_q}) begin
          quo_d = {quo_q[11:0], 1'b1};
          rem_d = (rem_q - {1'b0, div_q}) << 1;
        end else begin
          quo_d = {quo_q[11:0], 1'b0};
          rem_d = rem_q << 1;
        end
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd0) begin
          state_d = ST_NORM;
        end
      end
      ST_NORM: begin
        if (cls_a_q == FP_NAN || cls_b_q == FP_NAN ||
            (cls_a_q == FP_ZERO && cls_b_q == FP_ZERO) ||
            (cls_a_q == FP_INF && cls_b_q == FP_INF)) begin
          result_d = QNAN;
        end else if (cls_a_q == FP_INF || cls_b_q == FP_ZERO) begin
          result_d = POS_INF | {sign_q, 15'h0000};
        end else if (cls_a_q == FP_ZERO || cls_b_q == FP_INF) begin
          result_d = {sign_q, 15'h0000};
        end else begin
          result_d = rounded_w;
        end
        dvo_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ready_out      = (state_q == ST_IDLE);
  assign result         = result_q;
  assign data_valid_out = dvo_q;

endmodule
